register_diff: RTL and testbench

//  - 4-bit serial-in/parallel-out shift register (SIPO); one new bit from d_in per rising clk edge.
//  - out exposes the last WIDTH sampled bits; the newest bit is out[0] and the oldest is out[WIDTH-1].
//  - Sits at a serial-to-parallel boundary, e.g. deserialising a 1-bit stream into a nibble for downstream logic.

---
 rtl/register_diff.sv | 32 +++
 tb/tb_register_diff.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/register_diff.sv
// register_diff: WIDTH-bit serial-in/parallel-out shift register.
// Ports: clk, reset (async, active-low), d_in (serial in), out (parallel, registered).
module register_diff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] out,
  input  logic             d_in,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shift_q;

  // Newest bit enters at bit 0; the MSB falls off.
  always_comb begin
    shift_d = {shift_q[WIDTH-2:0], d_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= RESET_VAL;
    end else begin
      shift_q <= shift_d;
    end
  end

  // Straight from the flops: no path from d_in to out.
  assign out = shift_q;

endmodule

// File: tb/tb_register_diff.sv
// tb_register_diff: directed and random checks of register_diff
// against a bit-history model of the last four sampled bits.
module tb_register_diff;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b0000;

  logic         clk;
  logic         reset;
  logic         d_in;
  logic [W-1:0] out;

  int vectors;
  int miscompares;

  // hist[0] is the most recently sampled bit since the last reset.
  logic hist[$];

  register_diff #(
    .WIDTH(W),
    .RESET_VAL(RV)
  ) dut (
    .out(out),
    .d_in(d_in),
    .clk(clk),
    .reset(reset)
  );

  initial clk = 1'b1;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] e;
    logic [W-1:0] rv;
    rv = RV;
    for (int i = 0; i < W; i++) begin
      e[i] = (i < hist.size()) ? hist[i] : rv[i];
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    vectors++;
    assert (out === exp) else begin
      miscompares++;
      $error("FAIL %s: out=%b required=%b", tag, out, exp);
    end
  endtask

  // Entered at a falling edge; drives d_in, takes one rising edge,
  // checks 1 ns later, returns at the next falling edge.
  task automatic step(input logic d, input logic [W-1:0] req,
                      input bit use_req, input string tag);
    d_in = d;
    @(posedge clk);
    if (reset === 1'b1) begin
      hist.push_front(d);
      if (hist.size() > W) void'(hist.pop_back());
    end
    #1;
    check(tag, model_out());
    if (use_req) check({tag, "_req"}, req);
    @(negedge clk);
  endtask

  logic [W-1:0] pat;
  logic         rb;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    d_in        = 1'b0;

    // Reset state
    #1;
    check("reset_state", 4'b0000);
    #9;
    reset = 1'b1;

    // Directed stream: edges 20..120 ns
    step(1'b0, 4'b0000, 1, "stream_e20");
    step(1'b1, 4'b0001, 1, "stream_e40");
    step(1'b0, 4'b0010, 1, "stream_e60");
    step(1'b1, 4'b0101, 1, "stream_e80");
    step(1'b1, 4'b1011, 1, "stream_e100");
    step(1'b1, 4'b0111, 1, "stream_e120");

    // Preload ones, then asynchronous reset between edges
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, i == 3, "preload");
    #3;
    reset = 1'b0;
    hist.delete();
    #1;
    check("async_rst", 4'b0000);

    // Reset held low: edges and d_in are ignored
    for (int i = 0; i < 5; i++) step(i[0] ? 1'b0 : 1'b1, 4'b0000, 1, "rst_held");
    reset = 1'b1;
    step(1'b1, 4'b0001, 1, "rst_release");

    // Build 1011, then a short reset pulse
    step(1'b0, 4'b0010, 1, "mid_0010");
    step(1'b1, 4'b0101, 1, "mid_0101");
    step(1'b1, 4'b1011, 1, "mid_1011");
    #2;
    reset = 1'b0;
    hist.delete();
    #1;
    check("mid_pulse", 4'b0000);
    #2;
    reset = 1'b1;
    step(1'b1, 4'b0001, 1, "mid_resume");

    // Fill and flush
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, i == 3, "fill");
    step(1'b0, 4'b1110, 1, "flush1");
    step(1'b0, 4'b1100, 1, "flush2");
    step(1'b0, 4'b1000, 1, "flush3");
    step(1'b0, 4'b0000, 1, "flush4");

    // 1010 shifted MSB-first, then one more bit
    pat = 4'b1010;
    for (int i = W - 1; i >= 0; i--) step(pat[i], 4'b1010, i == 0, "pat");
    step(1'b1, 4'b0101, 1, "pat_drop");

    // Random stream with occasional reset pulses
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        #3;
        reset = 1'b0;
        hist.delete();
        #1;
        check("rand_rst", 4'b0000);
        #2;
        reset = 1'b1;
      end
      rb = 1'($urandom_range(0, 1));
      step(rb, 4'b0000, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
